tcl_egress_merge: RTL and testbench

TCL_EGRESS_MERGE -- requirements
Module: tcl_egress_merge

---
 rtl/tcl_egress_merge.sv | 203 ++++++++++++++++++++
 tb/tb_tcl_egress_merge.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcl_egress_merge.sv
// Four-port egress merger: per-port 8x12 FIFOs drained round-robin into an 8x12 output FIFO,
// with threshold-driven backpressure, status flags and per-source word counters.
module tcl_egress_merge (
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic [2:0]  Umbral_alto,
   input  logic [2:0]  Umbral_bajo,
   input  logic        pushP0,
   input  logic        pushP1,
   input  logic        pushP2,
   input  logic        pushP3,
   input  logic [11:0] dataInP0,
   input  logic [11:0] dataInP1,
   input  logic [11:0] dataInP2,
   input  logic [11:0] dataInP3,
   output logic        almostFullP0,
   output logic        almostFullP1,
   output logic        almostFullP2,
   output logic        almostFullP3,
   input  logic        popOut,
   output logic [11:0] dataOut,
   output logic        validOut,
   output logic        almostEmptyOut,
   output logic        emptyOut,
   input  logic        req,
   input  logic [2:0]  idx,
   output logic [4:0]  counterOut,
   output logic        counterValid,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_RESET  = 4'b0001,
      S_INIT   = 4'b0010,
      S_IDLE   = 4'b0100,
      S_ACTIVE = 4'b1000
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  alto_q, bajo_q;
   logic [11:0] pmem_q [4][8];
   logic [3:0]  pocc_q [4];
   logic [2:0]  prd_q  [4];
   logic [2:0]  pwr_q  [4];
   logic [11:0] omem_q [8];
   logic [3:0]  oocc_q;
   logic [2:0]  ord_q, owr_q;
   logic [1:0]  last_q;
   logic [4:0]  cnt_q  [5];
   logic [11:0] dout_q;
   logic        vout_q;
   logic [4:0]  cout_q;
   logic        cval_q;

   logic [3:0]  push, nonempty, ppop, pwe;
   logic [11:0] din   [4];
   logic [11:0] phead [4];
   logic [1:0]  gnt, cand;
   logic        found, xfer, opop, accept;
   logic [4:0]  csel;

   assign push   = {pushP3, pushP2, pushP1, pushP0};
   assign din[0] = dataInP0;
   assign din[1] = dataInP1;
   assign din[2] = dataInP2;
   assign din[3] = dataInP3;

   always_comb begin
      for (int unsigned n = 0; n < 4; n++) begin
         nonempty[n] = (pocc_q[n] != '0);
         phead[n]    = pmem_q[n][prd_q[n]];
      end
   end

   // Round-robin search starts one past the last granted port; k=4 wraps back to last_q itself.
   always_comb begin
      gnt   = last_q;
      found = 1'b0;
      cand  = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = last_q + 2'(k);
         if (!found && nonempty[cand]) begin
            gnt   = cand;
            found = 1'b1;
         end
      end
   end

   assign accept = (state_q == S_IDLE) || (state_q == S_ACTIVE);
   assign xfer   = (state_q == S_ACTIVE) && (oocc_q < {1'b0, alto_q}) && (|nonempty);
   assign opop   = popOut && (state_q != S_RESET) && (oocc_q != '0);

   // A full port FIFO still accepts a push on the cycle it is being drained.
   always_comb begin
      for (int unsigned n = 0; n < 4; n++) begin
         ppop[n] = xfer && (gnt == 2'(n));
         pwe[n]  = !reset && accept && push[n] && ((pocc_q[n] != 4'd8) || ppop[n]);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RESET:  state_d = S_INIT;
         S_INIT:   if (!init) state_d = S_IDLE;
         S_IDLE:   if (init) state_d = S_INIT;
                   else if (|nonempty) state_d = S_ACTIVE;
         S_ACTIVE: if (init) state_d = S_INIT;
                   else if (!(|nonempty)) state_d = S_IDLE;
         default:  state_d = S_RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_RESET;
      else       state_q <= state_d;
   end

   always_comb begin
      csel = '0;
      case (idx)
         3'd0:    csel = cnt_q[0];
         3'd1:    csel = cnt_q[1];
         3'd2:    csel = cnt_q[2];
         3'd3:    csel = cnt_q[3];
         3'd4:    csel = cnt_q[4];
         default: csel = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      for (int unsigned n = 0; n < 4; n++)
         if (pwe[n]) pmem_q[n][pwr_q[n]] <= din[n];
      if (xfer) omem_q[owr_q] <= phead[gnt];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned n = 0; n < 4; n++) begin
            pocc_q[n] <= '0;
            prd_q[n]  <= '0;
            pwr_q[n]  <= '0;
         end
         for (int unsigned n = 0; n < 5; n++) cnt_q[n] <= '0;
         oocc_q <= '0;
         ord_q  <= '0;
         owr_q  <= '0;
         last_q <= 2'd3;
         alto_q <= 3'd6;
         bajo_q <= 3'd1;
         dout_q <= '0;
         vout_q <= 1'b0;
         cout_q <= '0;
         cval_q <= 1'b0;
      end else begin
         if (state_q == S_INIT && init) begin
            alto_q <= Umbral_alto;
            bajo_q <= Umbral_bajo;
         end
         for (int unsigned n = 0; n < 4; n++) begin
            if (pwe[n])  pwr_q[n] <= pwr_q[n] + 3'd1;
            if (ppop[n]) prd_q[n] <= prd_q[n] + 3'd1;
            if (pwe[n] && !ppop[n])      pocc_q[n] <= pocc_q[n] + 4'd1;
            else if (!pwe[n] && ppop[n]) pocc_q[n] <= pocc_q[n] - 4'd1;
         end
         if (xfer) begin
            owr_q       <= owr_q + 3'd1;
            last_q      <= gnt;
            cnt_q[gnt]  <= cnt_q[gnt] + 5'd1;
         end
         if (opop) begin
            ord_q    <= ord_q + 3'd1;
            dout_q   <= omem_q[ord_q];
            vout_q   <= 1'b1;
            cnt_q[4] <= cnt_q[4] + 5'd1;
         end else begin
            vout_q <= 1'b0;
         end
         if (xfer && !opop)      oocc_q <= oocc_q + 4'd1;
         else if (!xfer && opop) oocc_q <= oocc_q - 4'd1;
         if (state_q == S_IDLE && req) begin
            cout_q <= csel;
            cval_q <= 1'b1;
         end else begin
            cval_q <= 1'b0;
         end
      end
   end

   assign almostFullP0   = pocc_q[0] >= {1'b0, alto_q};
   assign almostFullP1   = pocc_q[1] >= {1'b0, alto_q};
   assign almostFullP2   = pocc_q[2] >= {1'b0, alto_q};
   assign almostFullP3   = pocc_q[3] >= {1'b0, alto_q};
   assign emptyOut       = (oocc_q == '0);
   assign almostEmptyOut = oocc_q <= {1'b0, bajo_q};
   assign dataOut        = dout_q;
   assign validOut       = vout_q;
   assign counterOut     = cout_q;
   assign counterValid   = cval_q;
   assign state          = state_q;

endmodule

// File: tb/tb_tcl_egress_merge.sv
// Bench for tcl_egress_merge: fixed vector table, directed multi-cycle sequences and a
// randomized run, all tracked by a queue-based reference model.
module tb_tcl_egress_merge;

   localparam logic [3:0] ST_RESET  = 4'b0001;
   localparam logic [3:0] ST_INIT   = 4'b0010;
   localparam logic [3:0] ST_IDLE   = 4'b0100;
   localparam logic [3:0] ST_ACTIVE = 4'b1000;

   logic        clk = 1'b0;
   logic        reset, init, popOut, req;
   logic [2:0]  Umbral_alto, Umbral_bajo, idx;
   logic [3:0]  push;
   logic [11:0] din [4];
   logic [11:0] dataOut;
   logic        validOut, almostEmptyOut, emptyOut, counterValid;
   logic [4:0]  counterOut;
   logic [3:0]  state, af;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tcl_egress_merge dut (
      .clk(clk), .reset(reset), .init(init),
      .Umbral_alto(Umbral_alto), .Umbral_bajo(Umbral_bajo),
      .pushP0(push[0]), .pushP1(push[1]), .pushP2(push[2]), .pushP3(push[3]),
      .dataInP0(din[0]), .dataInP1(din[1]), .dataInP2(din[2]), .dataInP3(din[3]),
      .almostFullP0(af[0]), .almostFullP1(af[1]), .almostFullP2(af[2]), .almostFullP3(af[3]),
      .popOut(popOut), .dataOut(dataOut), .validOut(validOut),
      .almostEmptyOut(almostEmptyOut), .emptyOut(emptyOut),
      .req(req), .idx(idx), .counterOut(counterOut), .counterValid(counterValid),
      .state(state)
   );

   // Reference model: plain queues and counters updated once per clock edge
   logic [11:0] mq [4][$];
   logic [11:0] moq [$];
   logic [3:0]  mst;
   logic [2:0]  malto, mbajo;
   int          mlast;
   logic [4:0]  mcnt [5];
   logic [11:0] mdout;
   logic        mvout, mcval;
   logic [4:0]  mcout;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit any, popok, xfer;
      int g;
      if (reset) begin
         for (int p = 0; p < 4; p++) mq[p].delete();
         moq.delete();
         mst = ST_RESET; malto = 3'd6; mbajo = 3'd1; mlast = 3;
         for (int i = 0; i < 5; i++) mcnt[i] = '0;
         mdout = '0; mvout = 1'b0; mcout = '0; mcval = 1'b0;
         return;
      end
      any = 1'b0;
      for (int p = 0; p < 4; p++) if (mq[p].size() > 0) any = 1'b1;
      if (mst == ST_IDLE && req) begin
         mcval = 1'b1;
         if (int'(idx) < 5) mcout = mcnt[int'(idx)]; else mcout = '0;
      end else mcval = 1'b0;
      popok = popOut && (mst != ST_RESET) && (moq.size() > 0);
      xfer  = (mst == ST_ACTIVE) && (moq.size() < int'(malto)) && any;
      if (popok) begin
         mdout = moq.pop_front(); mvout = 1'b1; mcnt[4] = mcnt[4] + 5'd1;
      end else mvout = 1'b0;
      if (xfer) begin
         g = -1;
         for (int k = 1; k <= 4; k++)
            if (g < 0 && mq[(mlast + k) % 4].size() > 0) g = (mlast + k) % 4;
         moq.push_back(mq[g].pop_front());
         mcnt[g] = mcnt[g] + 5'd1;
         mlast = g;
      end
      if (mst == ST_IDLE || mst == ST_ACTIVE)
         for (int p = 0; p < 4; p++)
            if (push[p] && mq[p].size() < 8) mq[p].push_back(din[p]);
      case (mst)
         ST_RESET: mst = ST_INIT;
         ST_INIT: begin
            if (init) begin malto = Umbral_alto; mbajo = Umbral_bajo; end
            else mst = ST_IDLE;
         end
         default: begin
            if (init) mst = ST_INIT;
            else if (mst == ST_IDLE && any) mst = ST_ACTIVE;
            else if (mst == ST_ACTIVE && !any) mst = ST_IDLE;
         end
      endcase
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("state", state, mst);
      chk("dataOut", dataOut, mdout);
      chk("validOut", validOut, mvout);
      chk("emptyOut", emptyOut, moq.size() == 0);
      chk("almostEmptyOut", almostEmptyOut, moq.size() <= int'(mbajo));
      for (int p = 0; p < 4; p++) chk("almostFull", af[p], mq[p].size() >= int'(malto));
      chk("counterValid", counterValid, mcval);
      chk("counterOut", counterOut, mcout);
   endtask

   task automatic idle_in();
      reset = 1'b0; init = 1'b0; push = '0; popOut = 1'b0; req = 1'b0; idx = '0;
   endtask

   task automatic reset_init(input logic [2:0] a, input logic [2:0] b);
      idle_in();
      reset = 1'b1; step();
      reset = 1'b0; init = 1'b1; Umbral_alto = a; Umbral_bajo = b;
      step(); step();
      init = 1'b0; step();
   endtask

   typedef struct {
      logic       rst, ini;
      logic [3:0] psh;
      logic       pop;
      logic [3:0] st;
      logic       emp, ae;
      logic [3:0] afx;
      logic       vld;
   } vec_t;

   vec_t        tbl [18];
   logic [11:0] got [16];
   int          n;

   initial begin
      idle_in();
      Umbral_alto = 3'd4; Umbral_bajo = 3'd2;
      for (int p = 0; p < 4; p++) din[p] = '0;

      // Threshold load, P0 fill against alto=4, reset mid-run
      tbl[0]  = '{1, 0, 4'h0, 0, ST_RESET,  1, 1, 4'h0, 0};
      tbl[1]  = '{0, 1, 4'h0, 0, ST_INIT,   1, 1, 4'h0, 0};
      tbl[2]  = '{0, 1, 4'h0, 0, ST_INIT,   1, 1, 4'h0, 0};
      tbl[3]  = '{0, 0, 4'h0, 0, ST_IDLE,   1, 1, 4'h0, 0};
      tbl[4]  = '{0, 0, 4'h1, 0, ST_IDLE,   1, 1, 4'h0, 0};
      tbl[5]  = '{0, 0, 4'h1, 0, ST_ACTIVE, 1, 1, 4'h0, 0};
      tbl[6]  = '{0, 0, 4'h1, 0, ST_ACTIVE, 0, 1, 4'h0, 0};
      tbl[7]  = '{0, 0, 4'h1, 0, ST_ACTIVE, 0, 1, 4'h0, 0};
      tbl[8]  = '{0, 0, 4'h1, 0, ST_ACTIVE, 0, 0, 4'h0, 0};
      tbl[9]  = '{0, 0, 4'h1, 0, ST_ACTIVE, 0, 0, 4'h0, 0};
      tbl[10] = '{0, 0, 4'h1, 0, ST_ACTIVE, 0, 0, 4'h0, 0};
      tbl[11] = '{0, 0, 4'h1, 0, ST_ACTIVE, 0, 0, 4'h1, 0};
      tbl[12] = '{0, 0, 4'h0, 1, ST_ACTIVE, 0, 0, 4'h1, 1};
      tbl[13] = '{0, 0, 4'h0, 1, ST_ACTIVE, 0, 0, 4'h0, 1};
      tbl[14] = '{1, 0, 4'hF, 1, ST_RESET,  1, 1, 4'h0, 0};
      tbl[15] = '{0, 0, 4'h0, 0, ST_INIT,   1, 1, 4'h0, 0};
      tbl[16] = '{0, 0, 4'h0, 0, ST_IDLE,   1, 1, 4'h0, 0};
      tbl[17] = '{0, 0, 4'h0, 1, ST_IDLE,   1, 1, 4'h0, 0};

      for (int i = 0; i < 18; i++) begin
         reset = tbl[i].rst; init = tbl[i].ini; push = tbl[i].psh; popOut = tbl[i].pop;
         for (int p = 0; p < 4; p++) din[p] = 12'(p * 256 + i);
         step();
         chk("tbl_state", state, tbl[i].st);
         chk("tbl_empty", emptyOut, tbl[i].emp);
         chk("tbl_almostEmpty", almostEmptyOut, tbl[i].ae);
         chk("tbl_almostFull", af, tbl[i].afx);
         chk("tbl_valid", validOut, tbl[i].vld);
      end

      // Round-robin order from two words per port
      reset_init(3'd6, 3'd1);
      for (int p = 0; p < 4; p++) din[p] = 12'(p * 12'h101 + 12'h0A0);
      push = 4'hF; step();
      for (int p = 0; p < 4; p++) din[p] = 12'(p * 12'h101 + 12'h0B0);
      step();
      push = '0; popOut = 1'b1; n = 0;
      for (int c = 0; c < 40 && n < 8; c++) begin
         step();
         if (validOut) begin got[n] = dataOut; n++; end
      end
      chk("rr_count", n, 8);
      for (int i = 0; i < 8; i++)
         chk("rr_word", got[i], (i < 4) ? i * 12'h101 + 12'h0A0 : (i - 4) * 12'h101 + 12'h0B0);

      // Overflow drop: alto=0 blocks arbitration while nine words are pushed to P1
      reset_init(3'd0, 3'd1);
      push = 4'h2;
      for (int i = 0; i < 9; i++) begin din[1] = 12'h500 + 12'(i); step(); end
      push = '0;
      chk("ovf_noxfer", emptyOut, 1);
      init = 1'b1; Umbral_alto = 3'd6; Umbral_bajo = 3'd1; step(); step();
      init = 1'b0; popOut = 1'b1; n = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (validOut && n < 16) begin got[n] = dataOut; n++; end
      end
      chk("ovf_count", n, 8);
      for (int i = 0; i < 8; i++) chk("ovf_word", got[i], 12'h500 + i);

      // Backpressure: output stalls at six words with popOut low
      reset_init(3'd6, 3'd5);
      push = 4'h3;
      for (int i = 0; i < 4; i++) begin din[0] = 12'h600 + 12'(i); din[1] = 12'h700 + 12'(i); step(); end
      push = '0;
      for (int c = 0; c < 15; c++) step();
      chk("bp_empty", emptyOut, 0);
      chk("bp_ae_at6", almostEmptyOut, 0);
      popOut = 1'b1; step();
      chk("bp_valid", validOut, 1);
      chk("bp_first", dataOut, 12'h600);
      chk("bp_ae_at5", almostEmptyOut, 1);
      popOut = 1'b0; step();
      chk("bp_refill", almostEmptyOut, 0);
      popOut = 1'b1; n = 0;
      for (int c = 0; c < 30; c++) begin step(); if (validOut) n++; end
      chk("bp_rest", n, 7);

      // Counter readout
      reset_init(3'd6, 3'd1);
      push = 4'h4;
      for (int i = 0; i < 3; i++) begin din[2] = 12'h2C0 + 12'(i); step(); end
      push = '0;
      for (int c = 0; c < 10; c++) step();
      popOut = 1'b1; n = 0;
      for (int c = 0; c < 3; c++) begin step(); if (validOut) n++; end
      chk("cnt_pops", n, 3);
      popOut = 1'b0;
      for (int c = 0; c < 3; c++) step();
      chk("cnt_idle", state, ST_IDLE);
      req = 1'b1;
      idx = 3'd2; step(); chk("cnt_idx2", counterOut, 3); chk("cnt_vld2", counterValid, 1);
      idx = 3'd4; step(); chk("cnt_idx4", counterOut, 3);
      idx = 3'd6; step(); chk("cnt_idx6", counterOut, 0); chk("cnt_vld6", counterValid, 1);
      idx = 3'd0; step(); chk("cnt_idx0", counterOut, 0);
      req = 1'b0; step(); chk("cnt_vld_off", counterValid, 0);

      // Reset while active with partly filled FIFOs
      reset_init(3'd6, 3'd1);
      push = 4'hF;
      for (int i = 0; i < 5; i++) begin
         for (int p = 0; p < 4; p++) din[p] = 12'($urandom);
         popOut = (i >= 3); step();
      end
      chk("rst_was_active", state, ST_ACTIVE);
      reset = 1'b1; step();
      chk("rst_state", state, ST_RESET);
      chk("rst_empty", emptyOut, 1);
      chk("rst_valid", validOut, 0);
      chk("rst_af", af, 0);
      reset = 1'b0; push = '0; popOut = 1'b0;
      init = 1'b1; step(); init = 1'b0; step(); step();
      req = 1'b1;
      for (int i = 0; i < 5; i++) begin idx = 3'(i); step(); chk("rst_cnt", counterOut, 0); end
      req = 1'b0;

      // Randomized run against the model
      for (int c = 0; c < 4000; c++) begin
         reset       = ($urandom_range(0, 199) == 0);
         init        = ($urandom_range(0, 39) == 0);
         Umbral_alto = 3'($urandom);
         Umbral_bajo = 3'($urandom);
         push        = 4'($urandom) & (((c / 300) % 2 == 0) ? 4'hF : 4'h5);
         for (int p = 0; p < 4; p++) din[p] = 12'($urandom);
         popOut      = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 3 : 8));
         req         = ($urandom_range(0, 3) == 0);
         idx         = 3'($urandom);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
